multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Control FSM for the multi-cycle RISC-V core (RV32I subset: lw, sw, R-type ALU, I-type ALU, jal, beq/bne).
- Sequences fetch / decode / execute / memory / writeback over the shared ALU, the single memory port and the immediate extender.
- Drives every datapath enable and mux select, including imm_src for the extender.
- Handshakes with memory through a req/ready pair.

Parameters:
RESET_PC_WRITE, 0, when 1 asserts pc_write for one cycle after reset release (PC reload); when 0, no extra cycle.

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0] (registered IR)
funct3  in  3  IR[14:12]
funct7b5  in  1  IR[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the access this cycle
mem_req  out  1  memory access request
mem_write  out  1  write qualifier for mem_req
adr_src  out  1  0 = PC, 1 = ALUOut register
ir_write  out  1  load IR and OldPC
pc_write  out  1  load PC from result bus
reg_write  out  1  register-file write
result_src  out  2  00 ALUOut, 01 Data reg, 10 ALU result
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 reg
alu_src_b  out  2  00 rs2 reg, 01 ImmExt, 10 constant 4
alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  out  2  00 I, 01 S, 10 B, 11 J
illegal  out  1  sticky illegal-instruction flag
state  out  4  current state (debug)

Behaviour:
- Single clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset:
  - state = FETCH (0), illegal = 0.
  - mem_req, mem_write, ir_write, pc_write and reg_write are forced to 0 while rst_n = 0.
  - Reset mid-access aborts the access; no enable glitches.
- Output model:
  - Outputs are combinational from state, plus opcode/funct3/zero where noted.
  - Unlisted outputs default to 0 / 00 / 000.
- States, encodings 0-11, with outputs and transitions:
  - FETCH: mem_req=1, adr_src=0.
    - If !mem_ready: hold the state; all enables stay 0.
    - On mem_ready: ir_write=1, pc_write=1, alu_src_a=00, alu_src_b=10, add, result_src=10 -> DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, add.
    - imm_src=11 if opcode=1101111, else 10.
    - Next state: lw 0000011 / sw 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ.
    - Any other opcode, or any funct3 not supported for that opcode, -> TRAP.
  - MEMADR: alu_src_a=10, alu_src_b=01, add.
    - imm_src=00 for lw, 01 for sw.
    - Next: MEMREAD (lw) / MEMWRITE (sw).
  - MEMREAD: mem_req=1, adr_src=1. Hold until mem_ready -> MEMWB.
  - MEMWB: result_src=01, reg_write=1 -> FETCH.
  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Hold until mem_ready -> FETCH.
  - EXECUTER: alu_src_a=10, alu_src_b=00, alu_ctrl from the decoder -> ALUWB.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, imm_src=00, alu_ctrl from the decoder -> ALUWB.
  - ALUWB: result_src=00, reg_write=1 -> FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1 -> ALUWB (rd = OldPC+4).
  - BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00.
    - pc_write = zero for funct3 000, !zero for funct3 001.
    - -> FETCH.
  - TRAP: illegal=1 (registered, sticky); all enables 0; stays in TRAP until reset.
- ALU decode:
  - R-type: funct3 000 -> add, or sub if funct7b5=1; 010 slt; 110 or; 111 and.
  - I-type: same funct3 map, but funct7b5 is ignored (000 is always add).
  - Other funct3 is illegal.
- Handshake rules:
  - mem_req stays high continuously until the cycle in which mem_ready=1.
  - mem_ready while mem_req=0 is ignored.
  - mem_ready on the FETCH request cycle completes with zero wait states.
- Latency with zero wait states, cycles from FETCH to the next FETCH: lw 5, sw 4, R/I 4, jal 4, beq/bne 3.
- RESET_PC_WRITE=1: the first cycle after rst_n rises is spent in FETCH with pc_write=1 and mem_req=0; normal behaviour follows.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - imm_src codes (I/S/B/J);
  - alu_ctrl codes;
  - result_src / alu_src_a / alu_src_b select codes.
- Sub-module alu_decoder (combinational): inputs alu_op class (add / sub / funct), funct3, funct7b5, is_rtype; outputs alu_ctrl and legal.

Test Plan:
- lw x5,8(x1) (IR=0x0080A283), mem_ready always 1 -> states 0,1,2,3,4,0. imm_src=00 in MEMADR; reg_write=1 only in MEMWB with result_src=01; 5 cycles.
- sw with mem_ready low for 3 cycles in MEMWRITE -> mem_req=mem_write=1 held for 4 cycles, state held at 5, exits to FETCH on the ready cycle; imm_src=01 in MEMADR.
- beq funct3=000: zero=1 -> pc_write=1 in BEQ, alu_ctrl=001. Repeat with zero=0 -> pc_write=0. bne (001) with zero=0 -> pc_write=1.
- R-type funct3=000, funct7b5=1 -> alu_ctrl=001 in EXECUTER. I-type funct3=000 with IR[30]=1 -> alu_ctrl=000. R-type funct3=111 -> 010.
- opcode 0001111 -> DECODE then TRAP; illegal=1 persists for 20 cycles regardless of mem_ready; rst_n low -> illegal=0, state=0.
- rst_n asserted mid-MEMREAD (asynchronously, between edges) -> state=0 and all enables 0 immediately. jal in DECODE -> imm_src=11; JAL state -> pc_write=1, then ALUWB with reg_write=1.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control path:
// FSM states, opcodes, datapath select codes and the decode-stage dispatch.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Dispatch out of DECODE; anything not explicitly supported lands in TRAP.
    function automatic state_t decode_next(input logic [6:0] op,
                                           input logic [2:0] f3,
                                           input logic       alu_legal);
        state_t nxt;
        case (op)
            OP_LOAD, OP_STORE: nxt = (f3 == F3_WORD) ? S_MEMADR : S_TRAP;
            OP_RTYPE:          nxt = alu_legal ? S_EXECUTER : S_TRAP;
            OP_ITYPE:          nxt = alu_legal ? S_EXECUTEI : S_TRAP;
            OP_JAL:            nxt = S_JAL;
            OP_BRANCH:         nxt = (f3 == F3_BEQ || f3 == F3_BNE) ? S_BEQ : S_TRAP;
            default:           nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the ALU operation class plus funct3/funct7b5 onto an alu_ctrl code,
// flagging funct3 values the core does not implement.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [2:0] alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // IR[30] selects sub only for register-register ops; for addi it is immediate data
                    3'b000:  alu_ctrl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: legal    = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM of the multi-cycle RV32I core: sequences the shared ALU, the
// single memory port and the immediate extender, with a req/ready memory handshake.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter logic RESET_PC_WRITE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] imm_src,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     state_reg;
    state_t     state_next;
    logic       illegal_reg;
    logic       pc_reload_reg;

    alu_op_t    alu_op;
    logic [2:0] dec_alu_ctrl;
    logic       dec_legal;

    logic       mem_req_comb;
    logic       mem_write_comb;
    logic       ir_write_comb;
    logic       pc_write_comb;
    logic       reg_write_comb;

    assign state   = state_reg;
    assign illegal = illegal_reg;

    // DECODE also uses the funct decode, but only for its legality verdict.
    always_comb begin
        case (state_reg)
            S_DECODE, S_EXECUTER, S_EXECUTEI: alu_op = ALUOP_FUNCT;
            S_BEQ:                            alu_op = ALUOP_SUB;
            default:                          alu_op = ALUOP_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .is_rtype (opcode == OP_RTYPE),
        .alu_ctrl (dec_alu_ctrl),
        .legal    (dec_legal)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:    if (!pc_reload_reg && mem_ready) state_next = S_DECODE;
            S_DECODE:   state_next = decode_next(opcode, funct3, dec_legal);
            S_MEMADR:   state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_BEQ:      state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_FETCH;
            illegal_reg   <= 1'b0;
            pc_reload_reg <= RESET_PC_WRITE;
        end else begin
            state_reg     <= state_next;
            pc_reload_reg <= 1'b0;
            if (state_next == S_TRAP) illegal_reg <= 1'b1;
        end
    end

    always_comb begin
        mem_req_comb   = 1'b0;
        mem_write_comb = 1'b0;
        ir_write_comb  = 1'b0;
        pc_write_comb  = 1'b0;
        reg_write_comb = 1'b0;
        adr_src        = 1'b0;
        result_src     = RES_ALUOUT;
        alu_src_a      = SRCA_PC;
        alu_src_b      = SRCB_RS2;
        alu_ctrl       = ALU_ADD;
        imm_src        = IMM_I;
        case (state_reg)
            S_FETCH: begin
                if (pc_reload_reg) begin
                    pc_write_comb = 1'b1;
                end else begin
                    mem_req_comb = 1'b1;
                    if (mem_ready) begin
                        ir_write_comb = 1'b1;
                        pc_write_comb = 1'b1;
                        alu_src_a     = SRCA_PC;
                        alu_src_b     = SRCB_FOUR;
                        result_src    = RES_ALU;
                    end
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                mem_req_comb = 1'b1;
                adr_src      = 1'b1;
            end
            S_MEMWB: begin
                result_src     = RES_DATA;
                reg_write_comb = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_comb   = 1'b1;
                mem_write_comb = 1'b1;
                adr_src        = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_ctrl  = dec_alu_ctrl;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_I;
                alu_ctrl  = dec_alu_ctrl;
            end
            S_ALUWB: begin
                result_src     = RES_ALUOUT;
                reg_write_comb = 1'b1;
            end
            S_JAL: begin
                alu_src_a     = SRCA_OLDPC;
                alu_src_b     = SRCB_FOUR;
                result_src    = RES_ALUOUT;
                pc_write_comb = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = SRCA_RS1;
                alu_src_b     = SRCB_RS2;
                alu_ctrl      = dec_alu_ctrl;
                result_src    = RES_ALUOUT;
                // only beq (000) and bne (001) can reach this state
                pc_write_comb = funct3[0] ? !zero : zero;
            end
            default: ;
        endcase
    end

    // Enables are qualified by rst_n so an asynchronous reset kills them at once.
    assign mem_req   = rst_n & mem_req_comb;
    assign mem_write = rst_n & mem_write_comb;
    assign ir_write  = rst_n & ir_write_comb;
    assign pc_write  = rst_n & pc_write_comb;
    assign reg_write = rst_n & reg_write_comb;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// the FSM and checks states and control outputs against hand-derived values.
module tb_multicycle_ctrl;
    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] imm_src;
    logic       illegal;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .imm_src    (imm_src),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ir(input logic [31:0] ir);
        opcode   = ir[6:0];
        funct3   = ir[14:12];
        funct7b5 = ir[30];
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic f7b5);
        return {1'b0, f7b5, 15'b0, f3, 5'b0, op};
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic cyc(input logic rdy, input logic z);
        @(negedge clk);
        mem_ready = rdy;
        zero      = z;
        #1;
    endtask

    // FETCH with zero wait states followed by DECODE.
    task automatic fetch_decode(input string name, input logic [1:0] exp_imm);
        cyc(1'b1, 1'b0);
        check({name, " fetch state"}, state, 0);
        check({name, " fetch ir_write"}, ir_write, 1);
        check({name, " fetch pc_write"}, pc_write, 1);
        cyc(1'b1, 1'b0);
        check({name, " decode state"}, state, 1);
        check({name, " decode imm_src"}, imm_src, exp_imm);
        check({name, " decode mem_req"}, mem_req, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("reset state", state, 0);
        check("reset illegal", illegal, 0);
        check("reset mem_req", mem_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        set_ir(32'h0);
        #12;
        check("por state", state, 0);
        check("por illegal", illegal, 0);
        check("por mem_req", mem_req, 0);
        check("por pc_write", pc_write, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // FETCH waits while memory is not ready
        cyc(1'b0, 1'b0);
        check("fetch wait mem_req", mem_req, 1);
        check("fetch wait ir_write", ir_write, 0);
        cyc(1'b0, 1'b0);
        check("fetch wait state", state, 0);

        // lw x5,8(x1)
        set_ir(32'h0080A283);
        fetch_decode("lw", 2'b10);
        cyc(1'b1, 1'b0);
        check("lw memadr state", state, 2);
        check("lw memadr imm_src", imm_src, 0);
        check("lw memadr src_a", alu_src_a, 2);
        cyc(1'b1, 1'b0);
        check("lw memread state", state, 3);
        check("lw memread req", mem_req, 1);
        check("lw memread adr_src", adr_src, 1);
        check("lw memread reg_write", reg_write, 0);
        cyc(1'b1, 1'b0);
        check("lw memwb state", state, 4);
        check("lw memwb reg_write", reg_write, 1);
        check("lw memwb result_src", result_src, 1);
        cyc(1'b0, 1'b0);
        check("lw back to fetch", state, 0);
        $display("txn lw: done, checks=%0d errors=%0d", checks, errors);

        // sw with 3 wait states
        set_ir(mk(7'b0100011, 3'b010, 1'b0));
        fetch_decode("sw", 2'b10);
        cyc(1'b0, 1'b0);
        check("sw memadr imm_src", imm_src, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(i == 3, 1'b0);
            check("sw memwrite state", state, 5);
            check("sw memwrite req", mem_req, 1);
            check("sw memwrite write", mem_write, 1);
        end
        cyc(1'b0, 1'b0);
        check("sw back to fetch", state, 0);
        $display("txn sw: done, checks=%0d errors=%0d", checks, errors);

        // beq taken, beq not taken, bne taken
        for (int k = 0; k < 3; k++) begin
            set_ir(mk(7'b1100011, (k == 2) ? 3'b001 : 3'b000, 1'b0));
            fetch_decode("br", 2'b10);
            cyc(1'b0, (k == 0));
            check("br state", state, 10);
            check("br alu_ctrl", alu_ctrl, 1);
            check("br pc_write", pc_write, (k != 1));
            cyc(1'b0, 1'b0);
            check("br back to fetch", state, 0);
            $display("txn branch %0d: done, checks=%0d errors=%0d", k, checks, errors);
        end

        // sub (R), addi with IR[30]=1 (I), and (R)
        set_ir(mk(7'b0110011, 3'b000, 1'b1));
        fetch_decode("sub", 2'b10);
        cyc(1'b0, 1'b0);
        check("sub state", state, 6);
        check("sub alu_ctrl", alu_ctrl, 1);
        check("sub src_b", alu_src_b, 0);
        cyc(1'b0, 1'b0);
        check("sub aluwb state", state, 8);
        check("sub aluwb reg_write", reg_write, 1);
        cyc(1'b0, 1'b0);
        $display("txn sub: done, checks=%0d errors=%0d", checks, errors);

        set_ir(mk(7'b0010011, 3'b000, 1'b1));
        fetch_decode("addi", 2'b10);
        cyc(1'b0, 1'b0);
        check("addi state", state, 7);
        check("addi alu_ctrl", alu_ctrl, 0);
        check("addi imm_src", imm_src, 0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        $display("txn addi: done, checks=%0d errors=%0d", checks, errors);

        set_ir(mk(7'b0110011, 3'b111, 1'b0));
        fetch_decode("and", 2'b10);
        cyc(1'b0, 1'b0);
        check("and alu_ctrl", alu_ctrl, 2);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        $display("txn and: done, checks=%0d errors=%0d", checks, errors);

        // jal
        set_ir(mk(7'b1101111, 3'b000, 1'b0));
        fetch_decode("jal", 2'b11);
        cyc(1'b0, 1'b0);
        check("jal state", state, 9);
        check("jal pc_write", pc_write, 1);
        check("jal src_b", alu_src_b, 2);
        cyc(1'b0, 1'b0);
        check("jal aluwb state", state, 8);
        check("jal aluwb reg_write", reg_write, 1);
        cyc(1'b0, 1'b0);
        check("jal back to fetch", state, 0);
        $display("txn jal: done, checks=%0d errors=%0d", checks, errors);

        // asynchronous reset in the middle of MEMREAD
        set_ir(32'h0080A283);
        fetch_decode("lw2", 2'b10);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("lw2 memread state", state, 3);
        #2 rst_n = 1'b0;
        #1;
        check("async rst state", state, 0);
        check("async rst mem_req", mem_req, 0);
        check("async rst pc_write", pc_write, 0);
        check("async rst ir_write", ir_write, 0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn async reset: done, checks=%0d errors=%0d", checks, errors);

        // unsupported opcode -> sticky TRAP
        set_ir(mk(7'b0001111, 3'b000, 1'b0));
        fetch_decode("fence", 2'b10);
        for (int i = 0; i < 20; i++) begin
            cyc(i[0], 1'b0);
            check("trap state", state, 11);
            check("trap illegal", illegal, 1);
            check("trap mem_req", mem_req, 0);
        end
        do_reset();
        $display("txn trap opcode: done, checks=%0d errors=%0d", checks, errors);

        // I-type with an unsupported funct3 also traps
        set_ir(mk(7'b0010011, 3'b001, 1'b0));
        fetch_decode("slli", 2'b10);
        cyc(1'b0, 1'b0);
        check("slli trap state", state, 11);
        check("slli illegal", illegal, 1);
        do_reset();
        $display("txn trap funct3: done, checks=%0d errors=%0d", checks, errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
